vt512_wb_image_ingest: RTL
==========================

Name: vt512_wb_image_ingest

Overview:
- Wishbone slave that owns the VT512 control/status registers and the image-data window.
- Buffers incoming image samples in a parametrised FIFO and streams them to the compute array over a valid/ready interface, tagged with x/y/channel coordinates.
- Tracks frame completion and raises an IRQ.
- Successor to the fixed single-window image capture path: programmable image size, multi-channel, back-pressure, frame status.

Parameters:
DATA_WIDTH, 32, sample width on Wishbone and stream (fixed 32 for WB compliance)
MAX_IMAGE_SIZE, 512, maximum width and height in pixels
NUM_CHANNELS, 3, samples per pixel (1..4)
FIFO_DEPTH, 16, sample FIFO entries (power of 2, >=2)
BASE_ADDR, 32'h414E_0000, block base; decode on wbs_adr_i[31:16]==BASE_ADDR[31:16]

Ports:
wb_clk_i  in  1  clock, all logic rising-edge
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  byte selects (registers honour per byte; DATA requires 4'hF, else dropped)
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack
wbs_dat_o  out  32  read data
pix_valid_o  out  1  stream sample valid
pix_ready_i  in  1  stream sample accept
pix_data_o  out  DATA_WIDTH  sample
pix_x_o  out  clog2(MAX_IMAGE_SIZE)  column of sample
pix_y_o  out  clog2(MAX_IMAGE_SIZE)  row of sample
pix_ch_o  out  2  channel index
pix_last_o  out  1  final sample of frame
irq_o  out  1  frame-done interrupt, level

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, pix_valid_o=0, pix_x/y/ch=0, pix_last_o=0, irq_o=0, FIFO empty, CTRL=0, IMG_W=IMG_H=MAX_IMAGE_SIZE, STATUS=0. Reset mid-frame discards FIFO and counters.
- Register map (offset = wbs_adr_i[15:0]):
  - 0x0000 CTRL RW: [0] enable, [1] soft_clear (self-clearing, reads 0), [2] irq_en.
  - 0x0004 STATUS: [0] busy RO, [1] frame_done W1C, [2] drop W1C, [3] fifo_full RO, [4] fifo_empty RO, [15:8] fifo level RO.
  - 0x0008 IMG_W RW; 0x000C IMG_H RW.
  - 0x4900 DATA WO.
  - Unmapped/other-base reads return 0 and ack; unmapped writes ack with no effect. DATA reads return 0.
- WB timing:
  - Ack is registered: asserted one cycle after cyc&stb, held for exactly one cycle, deasserted for at least one cycle before the next ack.
  - Read data is valid with ack.
- DATA write, FIFO full: ack withheld (wait states) until a FIFO slot frees. The sample is pushed in the ack cycle.
- DATA write while enable=0 or state=DONE: acked, sample dropped, drop=1.
- IMG_W/IMG_H:
  - Writes while busy are ignored.
  - Writes of 0 or >MAX_IMAGE_SIZE are ignored.
  - Stored width is clog2(MAX)+1 bits.
- FSM:
  - IDLE: enable=0.
  - IDLE -> RECV when enable is set.
  - RECV: busy=1. Counts accepted FIFO writes; after IMG_W*IMG_H*NUM_CHANNELS samples, -> DONE.
  - DONE: busy=1, further DATA writes are dropped. When the last sample handshakes on the stream: frame_done=1, -> IDLE, enable auto-clears.
- Clearing enable in RECV -> IDLE; FIFO and counters flush.
- soft_clear in any state: flush FIFO, zero counters, clear frame_done/drop, -> IDLE. CTRL.enable is unchanged but must be re-written to start.
- Stream:
  - pix_valid_o = FIFO non-empty (registered FWFT output).
  - Data and coordinates hold stable while valid&&!ready.
  - Coordinate order: ch fastest, then x, then y.
  - Wrap: ch at NUM_CHANNELS-1 -> 0 and x++; x at IMG_W-1 -> 0 and y++.
  - pix_last_o=1 on (IMG_W-1, IMG_H-1, NUM_CHANNELS-1).
- Simultaneous FIFO push and pop: level unchanged; allowed when full (pop frees the slot same cycle) and when empty (no bypass; valid rises next cycle).
- irq_o = frame_done & irq_en. Clears on W1C of STATUS[1].

Test Plan:
- Reset, read 0x0004 -> 0x0000_0010; read 0x0008 -> 512; ack exactly 1 cycle after stb.
- IMG_W=2, IMG_H=2, NUM_CHANNELS=3, enable, write 12 samples 0..11, ready=1 -> outputs 0..11 with (x,y,ch) sequencing (0,0,0)...(1,1,2); pix_last on sample 11; frame_done=1; CTRL.enable reads 0.
- FIFO_DEPTH=16, ready=0, write 17 samples -> 17th ack stalls; assert ready one cycle -> 17th acked next cycle; level stays 16.
- Write DATA with enable=0 -> ack, STATUS.drop=1, pix_valid_o stays 0; write 0x4 to STATUS -> drop=0.
- irq_en=1, complete a 1x1x3 frame -> irq_o=1; write 0x2 to STATUS -> irq_o=0 next cycle.
- Mid-frame (5 of 12 samples), assert wb_rst_ni=0 asynchronously -> all outputs 0 immediately; after release, FIFO empty, IMG_W=512.

Source files
------------

// File: rtl/vt512_wb_image_ingest.sv
// rtl/vt512_wb_image_ingest.sv - Wishbone image ingest: control/status registers, sample FIFO, x/y/ch tagged stream
module vt512_wb_image_ingest #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          MAX_IMAGE_SIZE = 512,
  parameter int          NUM_CHANNELS   = 3,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h414E_0000
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_ni,
  input  logic                              wbs_stb_i,
  input  logic                              wbs_cyc_i,
  input  logic                              wbs_we_i,
  input  logic [3:0]                        wbs_sel_i,
  input  logic [31:0]                       wbs_adr_i,
  input  logic [31:0]                       wbs_dat_i,
  output logic                              wbs_ack_o,
  output logic [31:0]                       wbs_dat_o,
  output logic                              pix_valid_o,
  input  logic                              pix_ready_i,
  output logic [DATA_WIDTH-1:0]             pix_data_o,
  output logic [$clog2(MAX_IMAGE_SIZE)-1:0] pix_x_o,
  output logic [$clog2(MAX_IMAGE_SIZE)-1:0] pix_y_o,
  output logic [1:0]                        pix_ch_o,
  output logic                              pix_last_o,
  output logic                              irq_o
);
  localparam int CW  = $clog2(MAX_IMAGE_SIZE);
  localparam int SW  = CW + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = AW + 1;
  localparam int PCW = $clog2(MAX_IMAGE_SIZE * MAX_IMAGE_SIZE * 4 + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  enable_q, enable_d, irq_en_q, irq_en_d;
  logic                  frame_done_q, frame_done_d, drop_q, drop_d;
  logic [SW-1:0]         img_w_q, img_w_d, img_h_q, img_h_d;
  logic [PCW-1:0]        push_cnt_q, push_cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]         x_q, x_d, y_q, y_d;
  logic [1:0]            ch_q, ch_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic        hit, req, empty, full, pop, data_wr, data_ok, do_push, wr_en, flush;
  logic [15:0] off;
  logic [31:0] rdata, w_m, h_m;
  logic [PCW-1:0] total;
  logic [CW-1:0]  w_last, h_last;
  logic           at_last;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    merge = old;
    for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  assign hit     = wbs_adr_i[31:16] == BASE_ADDR[31:16];
  assign off     = wbs_adr_i[15:0];
  assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == CNW'(FIFO_DEPTH);
  assign pop     = ~empty & pix_ready_i;
  assign data_wr = req & wbs_we_i & hit & (off == 16'h4900);
  assign data_ok = data_wr & (state_q == S_RECV) & (wbs_sel_i == 4'hF);
  // A full FIFO stalls the ack, unless the stream frees a slot this very cycle.
  assign ack_d   = req & ~(data_ok & full & ~pop);
  assign do_push = ack_d & data_ok;
  assign wr_en   = ack_d & wbs_we_i & hit;
  assign total   = PCW'(img_w_q) * PCW'(img_h_q) * PCW'(NUM_CHANNELS);
  assign w_last  = CW'(img_w_q - SW'(1));
  assign h_last  = CW'(img_h_q - SW'(1));
  assign at_last = (x_q == w_last) & (y_q == h_last) & (ch_q == 2'(NUM_CHANNELS - 1));
  assign w_m     = merge(32'(img_w_q), wbs_dat_i, wbs_sel_i);
  assign h_m     = merge(32'(img_h_q), wbs_dat_i, wbs_sel_i);

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        16'h0000: rdata = {29'd0, irq_en_q, 1'b0, enable_q};
        16'h0004: rdata = {16'd0, 8'(cnt_q), 3'd0, empty, full, drop_q, frame_done_q,
                           state_q != S_IDLE};
        16'h0008: rdata = 32'(img_w_q);
        16'h000C: rdata = 32'(img_h_q);
        default:  rdata = '0;
      endcase
    end
    dat_d = (ack_d & ~wbs_we_i) ? rdata : '0;
  end

  always_comb begin
    state_d = state_q;   enable_d = enable_q;   irq_en_d = irq_en_q;
    frame_done_d = frame_done_q;   drop_d = drop_q;
    img_w_d = img_w_q;   img_h_d = img_h_q;   push_cnt_d = push_cnt_q;
    wr_ptr_d = wr_ptr_q; rd_ptr_d = rd_ptr_q;
    x_d = x_q;   y_d = y_q;   ch_d = ch_q;   flush = 1'b0;
    cnt_d = cnt_q + CNW'(do_push) - CNW'(pop);

    if (wr_en && off == 16'h0004 && wbs_sel_i[0]) begin
      if (wbs_dat_i[1]) frame_done_d = 1'b0;
      if (wbs_dat_i[2]) drop_d = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (ch_q != 2'(NUM_CHANNELS - 1)) ch_d = ch_q + 2'd1;
      else begin
        ch_d = '0;
        if (x_q != w_last) x_d = x_q + CW'(1);
        else begin
          x_d = '0;
          y_d = (y_q == h_last) ? '0 : y_q + CW'(1);
        end
      end
      if (at_last && state_q == S_DONE) begin
        frame_done_d = 1'b1;
        enable_d     = 1'b0;
        state_d      = S_IDLE;
        push_cnt_d   = '0;
      end
    end
    if (do_push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      push_cnt_d = push_cnt_q + PCW'(1);
      if (push_cnt_q + PCW'(1) == total) state_d = S_DONE;
    end
    if (ack_d && data_wr && !data_ok) drop_d = 1'b1;
    // Geometry is frozen while a frame is in flight.
    if (wr_en && state_q == S_IDLE) begin
      if (off == 16'h0008 && w_m != 0 && w_m <= 32'(MAX_IMAGE_SIZE)) img_w_d = SW'(w_m);
      if (off == 16'h000C && h_m != 0 && h_m <= 32'(MAX_IMAGE_SIZE)) img_h_d = SW'(h_m);
    end
    if (wr_en && off == 16'h0000 && wbs_sel_i[0]) begin
      irq_en_d = wbs_dat_i[2];
      if (wbs_dat_i[1]) begin
        flush = 1'b1;   frame_done_d = 1'b0;   drop_d = 1'b0;   state_d = S_IDLE;
      end else begin
        enable_d = wbs_dat_i[0];
        if (!wbs_dat_i[0]) begin
          flush = 1'b1;   state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
          state_d = S_RECV;   push_cnt_d = '0;
        end
      end
    end
    if (flush) begin
      wr_ptr_d = '0;   rd_ptr_d = '0;   cnt_d = '0;   push_cnt_d = '0;
      x_d = '0;   y_d = '0;   ch_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;   ack_q <= 1'b0;   dat_q <= '0;
      enable_q <= 1'b0;   irq_en_q <= 1'b0;   frame_done_q <= 1'b0;   drop_q <= 1'b0;
      img_w_q <= SW'(MAX_IMAGE_SIZE);   img_h_q <= SW'(MAX_IMAGE_SIZE);
      push_cnt_q <= '0;   wr_ptr_q <= '0;   rd_ptr_q <= '0;   cnt_q <= '0;
      x_q <= '0;   y_q <= '0;   ch_q <= '0;
    end else begin
      state_q <= state_d;   ack_q <= ack_d;   dat_q <= dat_d;
      enable_q <= enable_d;   irq_en_q <= irq_en_d;
      frame_done_q <= frame_done_d;   drop_q <= drop_d;
      img_w_q <= img_w_d;   img_h_q <= img_h_d;
      push_cnt_q <= push_cnt_d;   wr_ptr_q <= wr_ptr_d;   rd_ptr_q <= rd_ptr_d;   cnt_q <= cnt_d;
      x_q <= x_d;   y_q <= y_d;   ch_q <= ch_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= DATA_WIDTH'(wbs_dat_i);
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign pix_valid_o = ~empty;
  assign pix_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign pix_x_o     = x_q;
  assign pix_y_o     = y_q;
  assign pix_ch_o    = ch_q;
  assign pix_last_o  = ~empty & at_last;
  assign irq_o       = frame_done_q & irq_en_q;
endmodule
